cycle_sequencer: RTL and testbench

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer.sv | 125 ++++++++++++
 tb/tb_cycle_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// Instruction cycle sequencer: latches opcode/addressing mode on acceptance and
// steps an execute-cycle counter whose length depends on the opcode.
module cycle_sequencer #(
    parameter int               INSTR_W = 16,
    parameter int               OPC_W   = 5,
    parameter int               ADDRM_W = 3,
    parameter int               CYC_W   = 4,
    parameter logic [OPC_W-1:0] MOV_OPC = 5'b00001,
    parameter logic [OPC_W-1:0] HLT_OPC = 5'b11111,
    parameter int               LEN_MOV = 4,
    parameter int               LEN_DEF = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               stall,
    input  logic               cycle_clear,
    output logic [1:0]         state,
    output logic [CYC_W-1:0]   cycle,
    output logic [OPC_W-1:0]   opcode,
    output logic [ADDRM_W-1:0] addrm,
    output logic               last_cycle
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HALT = 2'd2
    } state_t;

    // Execute lengths must be representable as a final index in the counter.
    if (LEN_MOV < 1 || LEN_MOV > (1 << CYC_W)) begin : g_bad_len_mov
        $error("cycle_sequencer: LEN_MOV out of range 1..2^CYC_W");
    end
    if (LEN_DEF < 1 || LEN_DEF > (1 << CYC_W)) begin : g_bad_len_def
        $error("cycle_sequencer: LEN_DEF out of range 1..2^CYC_W");
    end
    if (OPC_W + ADDRM_W > INSTR_W) begin : g_bad_fields
        $error("cycle_sequencer: opcode and addressing fields exceed INSTR_W");
    end

    localparam logic [CYC_W-1:0] LAST_MOV = CYC_W'(LEN_MOV - 1);
    localparam logic [CYC_W-1:0] LAST_DEF = CYC_W'(LEN_DEF - 1);

    state_t             state_q;
    logic [CYC_W-1:0]   cycle_q;
    logic [OPC_W-1:0]   opcode_q;
    logic [ADDRM_W-1:0] addrm_q;

    logic [OPC_W-1:0]   new_opcode;
    logic [ADDRM_W-1:0] new_addrm;
    logic [CYC_W-1:0]   last_idx;
    logic               accept;

    // Operand bits below the decoded fields are not used by the sequencer.
    if (OPC_W + ADDRM_W < INSTR_W) begin : g_operand
        logic unused_operand;
        assign unused_operand = ^instruction[INSTR_W-OPC_W-ADDRM_W-1:0];
    end

    assign new_opcode = instruction[INSTR_W-1 -: OPC_W];
    assign new_addrm  = (new_opcode == MOV_OPC) ? instruction[INSTR_W-OPC_W-1 -: ADDRM_W]
                                                : '0;

    assign last_idx    = (opcode_q == MOV_OPC) ? LAST_MOV : LAST_DEF;
    assign last_cycle  = (state_q == EXEC) && (cycle_q == last_idx);
    assign instr_ready = reset_n &&
                         ((state_q == IDLE) || (last_cycle && !stall && !cycle_clear));
    assign accept      = instr_valid && instr_ready;

    assign state  = state_q;
    assign cycle  = cycle_q;
    assign opcode = opcode_q;
    assign addrm  = addrm_q;

    // Clear beats stall, and both beat completion; acceptance only happens when
    // neither is asserted, so it is checked after them in EXEC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cycle_q  <= '0;
            opcode_q <= '0;
            addrm_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cycle_q <= '0;
                    if (accept) begin
                        opcode_q <= new_opcode;
                        addrm_q  <= new_addrm;
                        state_q  <= (new_opcode == HLT_OPC) ? HALT : EXEC;
                    end
                end
                EXEC: begin
                    if (cycle_clear) begin
                        cycle_q <= '0;
                    end else if (stall) begin
                        cycle_q <= cycle_q;
                    end else if (last_cycle) begin
                        cycle_q <= '0;
                        if (accept) begin
                            opcode_q <= new_opcode;
                            addrm_q  <= new_addrm;
                            state_q  <= (new_opcode == HLT_OPC) ? HALT : EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cycle_q <= cycle_q + 1'b1;
                    end
                end
                HALT: begin
                    cycle_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    cycle_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: directed scenarios checked by literal expectations
// and by a behavioural model compared on every falling clock edge.
module tb_cycle_sequencer;

    localparam int MOV     = 1;
    localparam int HLT     = 31;
    localparam int LEN_MOV = 4;
    localparam int LEN_DEF = 8;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        stall       = 1'b0;
    logic        cycle_clear = 1'b0;
    logic        instr_ready;
    logic [1:0]  state;
    logic [3:0]  cycle;
    logic [4:0]  opcode;
    logic [2:0]  addrm;
    logic        last_cycle;

    int vectors     = 0;
    int miscompares = 0;

    // Model: 0 idle, 1 executing, 2 halted.
    int m_state = 0;
    int m_cycle = 0;
    int m_opc   = 0;
    int m_addrm = 0;

    cycle_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall),
        .cycle_clear (cycle_clear),
        .state       (state),
        .cycle       (cycle),
        .opcode      (opcode),
        .addrm       (addrm),
        .last_cycle  (last_cycle)
    );

    always #5 clk = ~clk;

    function automatic int len_of(int op);
        return (op == MOV) ? LEN_MOV : LEN_DEF;
    endfunction

    function automatic bit exp_last();
        return reset_n && (m_state == 1) && (m_cycle == len_of(m_opc) - 1);
    endfunction

    function automatic bit exp_ready();
        return reset_n && ((m_state == 0) || (exp_last() && !stall && !cycle_clear));
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin : model
        int op;
        if (!reset_n) begin
            m_state = 0;
            m_cycle = 0;
            m_opc   = 0;
            m_addrm = 0;
        end else if (instr_valid && exp_ready()) begin
            op      = int'(instruction[15:11]);
            m_opc   = op;
            m_addrm = (op == MOV) ? int'(instruction[10:8]) : 0;
            m_cycle = 0;
            m_state = (op == HLT) ? 2 : 1;
        end else if (m_state == 1) begin
            if (cycle_clear) begin
                m_cycle = 0;
            end else if (!stall) begin
                if (m_cycle == len_of(m_opc) - 1) begin
                    m_state = 0;
                    m_cycle = 0;
                end else begin
                    m_cycle = m_cycle + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check_output("model.state",       int'(state),       m_state);
        check_output("model.cycle",       int'(cycle),       m_cycle);
        check_output("model.opcode",      int'(opcode),      m_opc);
        check_output("model.addrm",       int'(addrm),       m_addrm);
        check_output("model.last_cycle",  int'(last_cycle),  int'(exp_last()));
        check_output("model.instr_ready", int'(instr_ready), int'(exp_ready()));
    end

    task automatic apply_stimulus(input bit v, input logic [15:0] instr,
                                  input bit st, input bit cl);
        instr_valid = v;
        instruction = instr;
        stall       = st;
        cycle_clear = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset.state", int'(state), 0);
        check_output("reset.cycle", int'(cycle), 0);
        check_output("reset.ready", int'(instr_ready), 0);
        check_output("reset.last",  int'(last_cycle), 0);
        reset_n = 1'b1;
        #1;
        check_output("post_reset.ready", int'(instr_ready), 1);

        // MOV with addressing mode 2, four execute cycles.
        apply_stimulus(1, 16'h0A00, 0, 0);
        tick();
        apply_stimulus(0, 16'h0000, 0, 0);
        check_output("mov.opcode", int'(opcode), 1);
        check_output("mov.addrm",  int'(addrm), 2);
        check_output("mov.state",  int'(state), 1);
        check_output("mov.cycle0", int'(cycle), 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_output("mov.cycle", int'(cycle), i);
            check_output("mov.last",  int'(last_cycle), (i == 3) ? 1 : 0);
        end
        tick();
        check_output("mov.done_state", int'(state), 0);
        check_output("mov.hold_opcode", int'(opcode), 1);

        // Non-MOV: addressing field ignored, eight execute cycles.
        apply_stimulus(1, 16'h1200, 0, 0);
        tick();
        apply_stimulus(0, 16'h0000, 0, 0);
        check_output("def.addrm", int'(addrm), 0);
        for (int i = 0; i < 8; i++) begin
            check_output("def.state", int'(state), 1);
            check_output("def.cycle", int'(cycle), i);
            check_output("def.last",  int'(last_cycle), (i == 7) ? 1 : 0);
            tick();
        end
        check_output("def.done_state", int'(state), 0);

        // Back-to-back: valid held through the MOV's last cycle.
        apply_stimulus(1, 16'h0A00, 0, 0);
        tick();
        instruction = 16'h1200;
        repeat (3) tick();
        check_output("b2b.ready_at_last", int'(instr_ready), 1);
        tick();
        apply_stimulus(0, 16'h0000, 0, 0);
        check_output("b2b.state",  int'(state), 1);
        check_output("b2b.opcode", int'(opcode), 2);
        check_output("b2b.cycle",  int'(cycle), 0);
        repeat (8) tick();
        check_output("b2b.done_state", int'(state), 0);

        // Stall holds, clear wins over stall and over completion.
        apply_stimulus(1, 16'h0A00, 0, 0);
        tick();
        apply_stimulus(0, 16'h0000, 0, 0);
        repeat (2) tick();
        stall = 1'b1;
        repeat (3) tick();
        check_output("stall.cycle", int'(cycle), 2);
        check_output("stall.ready", int'(instr_ready), 0);
        cycle_clear = 1'b1;
        tick();
        check_output("clear.cycle", int'(cycle), 0);
        check_output("clear.state", int'(state), 1);
        apply_stimulus(0, 16'h0000, 0, 0);
        repeat (3) tick();
        check_output("clear.last_reached", int'(last_cycle), 1);
        apply_stimulus(1, 16'h1200, 0, 1);
        #1;
        check_output("clear.ready_blocked", int'(instr_ready), 0);
        tick();
        apply_stimulus(0, 16'h0000, 0, 0);
        check_output("clear_last.cycle",  int'(cycle), 0);
        check_output("clear_last.opcode", int'(opcode), 1);
        repeat (4) tick();
        check_output("clear.done_state", int'(state), 0);

        // Asynchronous reset in the middle of a long instruction.
        apply_stimulus(1, 16'h1200, 0, 0);
        tick();
        apply_stimulus(0, 16'h0000, 0, 0);
        repeat (5) tick();
        check_output("areset.pre_cycle", int'(cycle), 5);
        #2 reset_n = 1'b0;
        #1;
        check_output("areset.state",  int'(state), 0);
        check_output("areset.cycle",  int'(cycle), 0);
        check_output("areset.opcode", int'(opcode), 0);
        check_output("areset.last",   int'(last_cycle), 0);
        check_output("areset.ready",  int'(instr_ready), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check_output("areset.ready_after", int'(instr_ready), 1);

        // Halt ignores everything until reset.
        apply_stimulus(1, 16'hF800, 0, 0);
        tick();
        check_output("halt.state",  int'(state), 2);
        check_output("halt.ready",  int'(instr_ready), 0);
        check_output("halt.opcode", int'(opcode), 31);
        apply_stimulus(1, 16'h0A00, 1, 1);
        repeat (3) tick();
        check_output("halt.stay_state",  int'(state), 2);
        check_output("halt.stay_opcode", int'(opcode), 31);
        check_output("halt.cycle",       int'(cycle), 0);
        apply_stimulus(0, 16'h0000, 0, 0);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check_output("halt.exit_state", int'(state), 0);
        check_output("halt.exit_ready", int'(instr_ready), 1);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
